// File: rtl/m_unit_controller.sv
// RV32M sequencer: multiply in MUL_CYCLES cycles, restoring divide one quotient bit per cycle.
// Holds m_unit_stall while busy, then pulses m_unit_ready for one cycle with result and destination.
module m_unit_controller #(
   parameter int MUL_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m_unit_start,
   input  logic [2:0]  func3,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   input  logic [4:0]  rd,
   input  logic        flush,
   output logic [31:0] m_unit_result,
   output logic        m_unit_ready,
   output logic        m_unit_wr,
   output logic [4:0]  m_unit_dest,
   output logic        m_unit_stall
);
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);

   state_t      r_state, w_next;
   logic [4:0]  r_cnt, r_rd;
   logic [1:0]  r_func;
   logic [31:0] r_op1, r_op2, r_rem, r_quo, r_dvs, r_result;
   logic        r_neg_q, r_neg_r;

   logic        w_accept, w_sgn, w_dz, w_ovf;
   logic [31:0] w_abs1, w_abs2;
   logic        w_sa, w_sb;
   logic [63:0] w_a, w_b, w_prod;
   logic [31:0] w_mul_res;
   logic [32:0] w_shift, w_diff;
   logic        w_ge;
   logic [31:0] w_rem_n, w_quo_n, w_div_res;

   assign w_accept = (r_state == S_IDLE) && m_unit_start && !flush;
   assign w_sgn    = !func3[0];
   assign w_dz     = (op2 == 32'd0);
   assign w_ovf    = w_sgn && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
   assign w_abs1   = (w_sgn && op1[31]) ? -op1 : op1;
   assign w_abs2   = (w_sgn && op2[31]) ? -op2 : op2;

   // Low 64 bits of the 33x33 product: sign-extending to 64 and truncating is exact
   assign w_sa      = r_func[0] ^ r_func[1];
   assign w_sb      = (r_func == 2'b01);
   assign w_a       = {{32{w_sa & r_op1[31]}}, r_op1};
   assign w_b       = {{32{w_sb & r_op2[31]}}, r_op2};
   assign w_prod    = w_a * w_b;
   assign w_mul_res = (r_func == 2'b00) ? w_prod[31:0] : w_prod[63:32];

   // Partial remainder stays below the divisor, so bit 32 of the difference is the borrow
   assign w_shift   = {r_rem, r_quo[31]};
   assign w_diff    = w_shift - {1'b0, r_dvs};
   assign w_ge      = !w_diff[32];
   assign w_rem_n   = w_ge ? w_diff[31:0] : w_shift[31:0];
   assign w_quo_n   = {r_quo[30:0], w_ge};
   assign w_div_res = r_func[1] ? (r_neg_r ? -w_rem_n : w_rem_n)
                                : (r_neg_q ? -w_quo_n : w_quo_n);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) begin
            if (!func3[2])          w_next = S_MUL;
            else if (w_dz || w_ovf) w_next = S_DONE;
            else                    w_next = S_DIV;
         end
         S_MUL:  if (r_cnt == MUL_LAST) w_next = S_DONE;
         S_DIV:  if (r_cnt == 5'd31)    w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_rd     <= '0;
         r_func   <= '0;
         r_op1    <= '0;
         r_op2    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_result <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_func  <= func3[1:0];
               r_rd    <= rd;
               r_op1   <= op1;
               r_op2   <= op2;
               r_cnt   <= '0;
               r_rem   <= '0;
               r_quo   <= w_abs1;
               r_dvs   <= w_abs2;
               r_neg_q <= w_sgn && (op1[31] ^ op2[31]);
               r_neg_r <= w_sgn && op1[31];
               if (func3[2] && w_dz)       r_result <= func3[1] ? op1 : 32'hFFFF_FFFF;
               else if (func3[2] && w_ovf) r_result <= func3[1] ? 32'd0 : 32'h8000_0000;
            end
            S_MUL: begin
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == MUL_LAST) r_result <= w_mul_res;
            end
            S_DIV: begin
               r_cnt <= r_cnt + 5'd1;
               r_rem <= w_rem_n;
               r_quo <= w_quo_n;
               if (r_cnt == 5'd31) r_result <= w_div_res;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      m_unit_ready  = (r_state == S_DONE);
      m_unit_stall  = (r_state != S_IDLE);
      m_unit_result = m_unit_ready ? r_result : 32'd0;
      m_unit_dest   = m_unit_ready ? r_rd : 5'd0;
      m_unit_wr     = m_unit_ready && (r_rd != 5'd0);
   end
endmodule

// File: tb/tb_m_unit_controller.sv
// Bench for m_unit_controller: directed M-ops checked against literal values and an arithmetic reference model.
module tb_m_unit_controller;
   localparam int MUL_CYCLES = 1;

   logic        clk = 1'b0;
   logic        rst, m_unit_start, flush;
   logic [2:0]  func3;
   logic [31:0] op1, op2;
   logic [4:0]  rd;
   logic [31:0] m_unit_result;
   logic        m_unit_ready, m_unit_wr, m_unit_stall;
   logic [4:0]  m_unit_dest;

   m_unit_controller #(.MUL_CYCLES(MUL_CYCLES)) dut (
      .clk(clk), .rst(rst), .m_unit_start(m_unit_start), .func3(func3),
      .op1(op1), .op2(op2), .rd(rd), .flush(flush),
      .m_unit_result(m_unit_result), .m_unit_ready(m_unit_ready),
      .m_unit_wr(m_unit_wr), .m_unit_dest(m_unit_dest), .m_unit_stall(m_unit_stall)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   // Model: one outstanding op, busy over cycles (m_start, m_ready]
   int          m_start = -10;
   int          m_ready = -10;
   logic [31:0] m_res = '0;
   logic [4:0]  m_dest = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ub;
      logic [63:0] p;
      bit ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ub  = longint'({32'd0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      case (f)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (!f[2]) return MUL_CYCLES + 1;
      if (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
      return 33;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         bit busy, rdy;
         busy = (m_start < cyc) && (cyc <= m_ready);
         rdy  = (cyc == m_ready);
         chk("cyc_stall", {31'd0, m_unit_stall}, {31'd0, busy});
         chk("cyc_ready", {31'd0, m_unit_ready}, {31'd0, rdy});
         chk("cyc_wr", {31'd0, m_unit_wr}, {31'd0, rdy && (m_dest != 0)});
         if (rdy) begin
            chk("cyc_result", m_unit_result, m_res);
            chk("cyc_dest", {27'd0, m_unit_dest}, {27'd0, m_dest});
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Drives a start for one cycle; the model accepts it only if idle and not flushed
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input bit fl, output int t0);
      t0 = cyc;
      func3 = f; op1 = a; op2 = b; rd = r; flush = fl; m_unit_start = 1'b1;
      if (!fl && !rst && !((m_start < cyc) && (cyc <= m_ready))) begin
         m_start = cyc;
         m_ready = cyc + ref_lat(f, a, b);
         m_res   = ref_op(f, a, b);
         m_dest  = r;
      end
      tick();
      m_unit_start = 1'b0;
      flush = 1'b0;
   endtask

   task automatic wait_ready(input int t0, input int exp_lat, input logic [31:0] exp_res,
                             input logic [4:0] r, input string nm);
      int got;
      got = -1;
      while (got < 0 && cyc < t0 + 40) begin
         if (m_unit_ready) got = cyc - t0;
         else tick();
      end
      chk({nm, "_latency"}, 32'(got), 32'(exp_lat));
      if (got >= 0) begin
         chk({nm, "_result"}, m_unit_result, exp_res);
         chk({nm, "_dest"}, {27'd0, m_unit_dest}, {27'd0, r});
         chk({nm, "_wr"}, {31'd0, m_unit_wr}, {31'd0, r != 0});
      end
   endtask

   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input int lat, input logic [31:0] res, input string nm);
      int t0;
      tick();
      issue(f, a, b, r, 1'b0, t0);
      wait_ready(t0, lat, res, r, nm);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_result"}, m_unit_result, 32'd0);
      chk({nm, "_ready"}, {31'd0, m_unit_ready}, 32'd0);
      chk({nm, "_wr"}, {31'd0, m_unit_wr}, 32'd0);
      chk({nm, "_dest"}, {27'd0, m_unit_dest}, 32'd0);
      chk({nm, "_stall"}, {31'd0, m_unit_stall}, 32'd0);
   endtask

   initial begin
      int t0, t1;
      rst = 1'b1; m_unit_start = 1'b0; flush = 1'b0;
      func3 = '0; op1 = '0; op2 = '0; rd = '0;
      tick();
      tick();
      chk_zero("reset");
      rst = 1'b0;
      chk_en = 1'b1;

      do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 2, 32'hFFFF_FFEB, "mul");
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 2, 32'hFFFF_FFFE, "mulhu");
      do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 2, 32'h0000_0000, "mulh");
      do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 2, 32'hFFFF_FFFF, "mulhsu");
      do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 2, 32'h0000_0001, "mul_m1");
      do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd8, 2, 32'h4000_0000, "mulh_min");
      do_op(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd7, 33, 32'hFFFF_FFFA, "div");
      do_op(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd7, 33, 32'hFFFF_FFFE, "rem");
      do_op(3'd5, 32'hFFFF_FFEC, 32'd3, 5'd7, 33, 32'h5555_554E, "divu");
      do_op(3'd4, 32'd7, 32'hFFFF_FFFE, 5'd9, 33, 32'hFFFF_FFFD, "div_negdvs");
      do_op(3'd7, 32'd100, 32'd7, 5'd9, 33, 32'd2, "remu");
      do_op(3'd5, 32'd5, 32'd0, 5'd10, 1, 32'hFFFF_FFFF, "divu_by0");
      do_op(3'd7, 32'd5, 32'd0, 5'd10, 1, 32'd5, "remu_by0");
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1, 32'h8000_0000, "div_ovf");
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1, 32'd0, "rem_ovf");
      do_op(3'd0, 32'd3, 32'd4, 5'd0, 2, 32'd12, "mul_rd0");

      // Start arriving mid-divide must be dropped
      tick();
      issue(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd7, 1'b0, t0);
      repeat (5) tick();
      issue(3'd0, 32'd7, 32'd7, 5'd9, 1'b0, t1);
      wait_ready(t0, 33, 32'hFFFF_FFFA, 5'd7, "div_ignstart");

      // Flushed start in IDLE never raises stall
      tick();
      issue(3'd0, 32'd3, 32'd4, 5'd9, 1'b1, t0);
      repeat (4) tick();
      chk("flush_stall", {31'd0, m_unit_stall}, 32'd0);
      chk("flush_ready", {31'd0, m_unit_ready}, 32'd0);

      // Reset part-way through the divide, then a start right after
      tick();
      issue(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd7, 1'b0, t0);
      repeat (9) tick();
      rst = 1'b1;
      m_start = -10;
      m_ready = -10;
      tick();
      rst = 1'b0;
      chk_zero("midreset");
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1'b0, t0);
      wait_ready(t0, 2, 32'hFFFF_FFFE, 5'd12, "mulhu_after_rst");

      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
